// File: rtl/control_unit_fsm_pkg.sv
// Shared definitions for the accumulator-machine sequencer: opcodes, FSM states,
// ALU function codes and the decoded-control bundle.
package control_unit_fsm_pkg;

    localparam int INSTR_W = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LIT  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_NAND = 4'h4;
    localparam logic [3:0] OP_OUT  = 4'h5;
    localparam logic [3:0] OP_CMP  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JC   = 4'h9;
    localparam logic [3:0] OP_JNC  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JNZ  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] F_PASSA = 3'b000;
    localparam logic [2:0] F_SUB   = 3'b001;
    localparam logic [2:0] F_PASSB = 3'b010;
    localparam logic [2:0] F_ADD   = 3'b011;
    localparam logic [2:0] F_NAND  = 3'b100;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        JADDR  = 3'd3,
        JLOAD  = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        J_ALWAYS = 3'd0,
        J_C      = 3'd1,
        J_NC     = 3'd2,
        J_Z      = 3'd3,
        J_NZ     = 3'd4
    } jcond_t;

    typedef struct packed {
        logic [2:0] f;
        logic       use_db;
        logic       load_ff;
        logic       drive_r;
        logic       upd_flags;
        logic       is_jump;
        jcond_t     jump_cond;
        logic       is_halt;
    } dec_t;

    function automatic logic jump_taken(input jcond_t cond, input logic cf, input logic zf);
        logic t;
        case (cond)
            J_ALWAYS: t = 1'b1;
            J_C:      t = cf;
            J_NC:     t = ~cf;
            J_Z:      t = zf;
            J_NZ:     t = ~zf;
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/control_unit_fsm_decoder.sv
// Combinational opcode decoder: maps a 4-bit opcode to the datapath control bundle.
// Unassigned opcodes (7, D, E) decode exactly like NOP.
module instr_decoder
    import control_unit_fsm_pkg::*;
(
    input  logic [3:0] i_opcode,
    output dec_t       o_dec
);

    // Opcode to control-bundle lookup.
    always_comb begin
        o_dec = '{f: F_PASSA, use_db: 1'b0, load_ff: 1'b0, drive_r: 1'b0,
                  upd_flags: 1'b0, is_jump: 1'b0, jump_cond: J_ALWAYS, is_halt: 1'b0};
        case (i_opcode)
            OP_NOP:  o_dec.f = F_PASSA;
            OP_LIT:  begin o_dec.f = F_PASSB; o_dec.use_db = 1'b1; o_dec.load_ff = 1'b1; o_dec.upd_flags = 1'b1; end
            OP_ADD:  begin o_dec.f = F_ADD;   o_dec.use_db = 1'b1; o_dec.load_ff = 1'b1; o_dec.upd_flags = 1'b1; end
            OP_SUB:  begin o_dec.f = F_SUB;   o_dec.use_db = 1'b1; o_dec.load_ff = 1'b1; o_dec.upd_flags = 1'b1; end
            OP_NAND: begin o_dec.f = F_NAND;  o_dec.use_db = 1'b1; o_dec.load_ff = 1'b1; o_dec.upd_flags = 1'b1; end
            OP_OUT:  o_dec.drive_r = 1'b1;
            // CMP drives the subtractor for flags only; the accumulator keeps its value
            OP_CMP:  begin o_dec.f = F_SUB;   o_dec.use_db = 1'b1; o_dec.upd_flags = 1'b1; end
            OP_JMP:  begin o_dec.is_jump = 1'b1; o_dec.jump_cond = J_ALWAYS; end
            OP_JC:   begin o_dec.is_jump = 1'b1; o_dec.jump_cond = J_C;      end
            OP_JNC:  begin o_dec.is_jump = 1'b1; o_dec.jump_cond = J_NC;     end
            OP_JZ:   begin o_dec.is_jump = 1'b1; o_dec.jump_cond = J_Z;      end
            OP_JNZ:  begin o_dec.is_jump = 1'b1; o_dec.jump_cond = J_NZ;     end
            OP_HALT: o_dec.is_halt = 1'b1;
            default: o_dec.f = F_PASSA;
        endcase
    end

endmodule

// File: rtl/control_unit_fsm.sv
// Fetch/decode/execute sequencer for the 5-bit accumulator datapath. Reads a synchronous
// program ROM, keeps PC/IR and the C/ZE flags, and drives the ALU/bus controls in EXEC.
module control_unit_fsm
    import control_unit_fsm_pkg::*;
#(
    parameter int PC_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               C,
    input  logic               ZE,
    output logic [PC_W-1:0]    pc_addr,
    output logic [2:0]         F,
    output logic [4:0]         operand,
    output logic               enableDB,
    output logic               enableFF,
    output logic               enableR,
    output logic               halted
);

    state_t             r_state, w_state_nxt;
    logic [PC_W-1:0]    r_pc, w_pc_nxt, w_pc_inc;
    logic [INSTR_W-1:0] r_ir, w_ir_nxt;
    logic               r_cf, r_zf, w_cf_nxt, w_zf_nxt;
    logic [3:0]         w_opcode;
    dec_t               w_dec;

    assign pc_addr  = r_pc;
    assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    // In DECODE the fresh ROM byte is classified; afterwards the latched IR is.
    always_comb begin
        if (r_state == DECODE) begin
            w_opcode = instr[7:4];
        end else begin
            w_opcode = r_ir[7:4];
        end
    end

    instr_decoder u_decoder (
        .i_opcode (w_opcode),
        .o_dec    (w_dec)
    );

    // State, PC, IR and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_pc    <= {PC_W{1'b0}};
            r_ir    <= {INSTR_W{1'b0}};
            r_cf    <= 1'b0;
            r_zf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_cf    <= w_cf_nxt;
            r_zf    <= w_zf_nxt;
        end
    end

    // Next-state, register updates and EXEC-only datapath controls.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_cf_nxt    = r_cf;
        w_zf_nxt    = r_zf;
        F           = F_PASSA;
        operand     = 5'b00000;
        enableDB    = 1'b0;
        enableFF    = 1'b0;
        enableR     = 1'b0;
        halted      = 1'b0;
        case (r_state)
            FETCH: w_state_nxt = DECODE;
            DECODE: begin
                w_ir_nxt = instr;
                // HALT leaves PC pointing at the HALT byte itself
                if (w_dec.is_halt) begin
                    w_state_nxt = HALT;
                end else begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = w_dec.is_jump ? JADDR : EXEC;
                end
            end
            EXEC: begin
                F           = w_dec.f;
                operand     = w_dec.use_db ? {1'b0, r_ir[3:0]} : 5'b00000;
                enableDB    = w_dec.use_db;
                enableFF    = w_dec.load_ff;
                enableR     = w_dec.drive_r;
                w_state_nxt = FETCH;
                if (w_dec.upd_flags) begin
                    w_cf_nxt = C;
                    w_zf_nxt = ZE;
                end else begin
                    w_cf_nxt = r_cf;
                    w_zf_nxt = r_zf;
                end
            end
            JADDR: w_state_nxt = JLOAD;
            JLOAD: begin
                w_state_nxt = FETCH;
                if (jump_taken(w_dec.jump_cond, r_cf, r_zf)) begin
                    w_pc_nxt = PC_W'({r_ir[3:0], instr});
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            HALT: halted = 1'b1;
            default: w_state_nxt = FETCH;
        endcase
    end

endmodule
